// File: rtl/mw93_eeprom_slave.sv
// Microwire 93C46-compatible serial EEPROM responder, x16 organisation.
// Define MW93_BULK_OPS_EN to enable the ERAL/WRAL bulk commands.
module mw93_eeprom_slave #(
    parameter int                ADDR_W      = 6,
    parameter int                DATA_W      = 16,
    parameter int                BUSY_CYCLES = 64,
    parameter logic [DATA_W-1:0] INIT_VAL    = 16'hFFFF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cs,
    input  logic i_sk,
    input  logic i_di,
    output logic o_do,
    output logic o_do_oe,
    output logic o_busy,
    output logic o_wen
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = $clog2(DATA_W + 1);
    localparam int BW    = $clog2(BUSY_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OPC, S_ADDR, S_RD_DUMMY, S_RD_DATA, S_WR_DATA, S_WAIT_CS_LO, S_BUSY
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_WRITE, C_ERASE, C_ERAL, C_WRAL
    } cmd_t;

    state_t              r_state;
    state_t              w_state_nxt;
    cmd_t                r_cmd;
    cmd_t                w_cmd_dec;
    logic [2:0]          r_cs_sy;
    logic [2:0]          r_sk_sy;
    logic [1:0]          r_di_sy;
    logic [1:0]          r_opc;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_sr;
    logic [CW-1:0]       r_cnt;
    logic [BW-1:0]       r_bcnt;
    logic                r_wen;
    logic                r_busy;
    logic                r_do;
    logic                r_do_oe;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_cs_fall;
    logic                w_sk_rise;
    logic                w_sk_fall;
    logic                w_bit;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [1:0]          w_sub;
    logic                w_wr_path;
    logic                w_dispatch;
    logic                w_commit;
    logic [DATA_W-1:0]   w_rd_word;

    // Two-flop synchronisers; the third cs/sk stage holds the previous value for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cs_sy <= '0;
            r_sk_sy <= '0;
            r_di_sy <= '0;
        end else begin
            r_cs_sy <= {r_cs_sy[1:0], i_cs};
            r_sk_sy <= {r_sk_sy[1:0], i_sk};
            r_di_sy <= {r_di_sy[0], i_di};
        end
    end

    // sk edges only count while cs is high, which also gives a cs fall priority over an sk rise
    assign w_cs_fall  = ~r_cs_sy[1] & r_cs_sy[2];
    assign w_sk_rise  = r_sk_sy[1] & ~r_sk_sy[2] & r_cs_sy[1];
    assign w_sk_fall  = ~r_sk_sy[1] & r_sk_sy[2] & r_cs_sy[1];
    assign w_bit      = r_di_sy[1];
    assign w_addr_nxt = {r_addr[ADDR_W-2:0], w_bit};
    assign w_sub      = w_addr_nxt[ADDR_W-1 -: 2];
    assign w_wr_path  = (r_opc == 2'b01) || (r_opc == 2'b00 && w_sub == 2'b01);
    assign w_rd_word  = r_mem[r_addr];

    always_comb begin
        w_cmd_dec = C_NONE;
        case (r_opc)
            2'b01: w_cmd_dec = C_WRITE;
            2'b11: w_cmd_dec = C_ERASE;
            2'b00: begin
`ifdef MW93_BULK_OPS_EN
                if (w_sub == 2'b10)      w_cmd_dec = C_ERAL;
                else if (w_sub == 2'b01) w_cmd_dec = C_WRAL;
`endif
            end
            default: w_cmd_dec = C_NONE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dispatch  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE:     if (w_sk_rise && w_bit) w_state_nxt = S_OPC;
            S_OPC:      if (w_sk_rise && r_cnt == CW'(1)) w_state_nxt = S_ADDR;
            S_ADDR: begin
                if (w_sk_rise && r_cnt == CW'(ADDR_W - 1)) begin
                    w_dispatch = 1'b1;
                    if (r_opc == 2'b10)  w_state_nxt = S_RD_DUMMY;
                    else if (w_wr_path)  w_state_nxt = S_WR_DATA;
                    else                 w_state_nxt = S_WAIT_CS_LO;
                end
            end
            S_RD_DUMMY: if (w_sk_fall) w_state_nxt = S_RD_DATA;
            S_RD_DATA:  w_state_nxt = S_RD_DATA;
            S_WR_DATA:  if (w_sk_rise && r_cnt == CW'(DATA_W - 1)) w_state_nxt = S_WAIT_CS_LO;
            S_WAIT_CS_LO: begin
                if (w_cs_fall) begin
                    if (r_wen && r_cmd != C_NONE) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_BUSY;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_BUSY:     if (r_bcnt == BW'(BUSY_CYCLES - 1)) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
        // A cs fall mid-frame discards whatever was shifted so far
        if (w_cs_fall && r_state != S_WAIT_CS_LO && r_state != S_BUSY) begin
            w_state_nxt = S_IDLE;
            w_dispatch  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_opc   <= '0;
            r_addr  <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bcnt  <= '0;
            r_cmd   <= C_NONE;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_do    <= 1'b0;
            r_do_oe <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_sk_rise && w_bit) r_cnt <= '0;
                S_OPC: begin
                    if (w_sk_rise) begin
                        r_opc <= {r_opc[0], w_bit};
                        r_cnt <= (r_cnt == CW'(1)) ? '0 : r_cnt + CW'(1);
                    end
                end
                S_ADDR: begin
                    if (w_sk_rise) begin
                        r_addr <= w_addr_nxt;
                        r_cnt  <= r_cnt + CW'(1);
                    end
                    if (w_dispatch) begin
                        r_cnt <= '0;
                        r_cmd <= w_cmd_dec;
                        if (r_opc == 2'b10) begin
                            r_do_oe <= 1'b1;
                            r_do    <= 1'b0;
                        end
                        if (r_opc == 2'b00 && w_sub == 2'b11) r_wen <= 1'b1;
                        if (r_opc == 2'b00 && w_sub == 2'b00) r_wen <= 1'b0;
                    end
                end
                // r_cnt holds the bits still to shift out of r_sr; zero means fetch the next word
                S_RD_DUMMY, S_RD_DATA: begin
                    if (w_sk_fall) begin
                        if (r_state == S_RD_DUMMY || r_cnt == '0) begin
                            r_do  <= w_rd_word[DATA_W-1];
                            r_sr  <= {w_rd_word[DATA_W-2:0], 1'b0};
                            r_cnt <= CW'(DATA_W - 1);
                        end else begin
                            r_do  <= r_sr[DATA_W-1];
                            r_sr  <= {r_sr[DATA_W-2:0], 1'b0};
                            r_cnt <= r_cnt - CW'(1);
                            if (r_cnt == CW'(1)) r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_sk_rise) begin
                        r_sr  <= {r_sr[DATA_W-2:0], w_bit};
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_CS_LO: begin
                    if (w_commit) begin
                        r_busy <= 1'b1;
                        r_bcnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_bcnt  <= r_bcnt + BW'(1);
                    r_do    <= 1'b0;
                    r_do_oe <= r_cs_sy[1];
                    if (w_state_nxt == S_IDLE) begin
                        r_busy <= 1'b0;
                        r_do   <= r_cs_sy[1];
                    end
                end
                default: ;
            endcase
            if (w_cs_fall) begin
                r_do_oe <= 1'b0;
                r_do    <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT_VAL;
        end else if (w_commit) begin
            case (r_cmd)
                C_WRITE: r_mem[r_addr] <= r_sr;
                C_ERASE: r_mem[r_addr] <= INIT_VAL;
                C_ERAL:  for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT_VAL;
                C_WRAL:  for (int i = 0; i < DEPTH; i++) r_mem[i] <= r_sr;
                default: ;
            endcase
        end
    end

    assign o_do    = r_do;
    assign o_do_oe = r_do_oe;
    assign o_busy  = r_busy;
    assign o_wen   = r_wen;

endmodule

// File: tb/tb_mw93_eeprom_slave.sv
// Randomised bench for mw93_eeprom_slave against a word-level EEPROM model.
module tb_mw93_eeprom_slave;

    localparam int HALF = 50;
`ifdef MW93_BULK_OPS_EN
    localparam bit BULK = 1'b1;
`else
    localparam bit BULK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cs    = 1'b0;
    logic sk    = 1'b0;
    logic di    = 1'b0;
    logic dout, dout_oe, busy, wen;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_mem [64];
    logic        m_wen;

    always #5 clk = ~clk;

    mw93_eeprom_slave dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_cs    (cs),
        .i_sk    (sk),
        .i_di    (di),
        .o_do    (dout),
        .o_do_oe (dout_oe),
        .o_busy  (busy),
        .o_wen   (wen)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 16'hFFFF;
        m_wen = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        di = b;
        #HALF;
        sk = 1'b1;
        #HALF;
        sk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic cs_on();
        cs = 1'b1;
        #HALF;
    endtask

    // Non-read command of ndata data bits; probe raises cs during the busy phase.
    task automatic run_cmd(input string tag, input logic [1:0] opc, input logic [5:0] addr,
                           input logic [15:0] data, input int ndata, input bit probe);
        bit commit;
        cs_on();
        send_bits({23'd0, 1'b1, opc, addr}, 9);
        for (int i = 15; i > 15 - ndata; i--) send_bit(data[i]);
        #HALF;
        cs = 1'b0;
        commit = 1'b0;
        case (opc)
            2'b01: if (m_wen && ndata == 16) begin m_mem[addr] = data; commit = 1'b1; end
            2'b11: if (m_wen) begin m_mem[addr] = 16'hFFFF; commit = 1'b1; end
            2'b00: begin
                case (addr[5:4])
                    2'b11: m_wen = 1'b1;
                    2'b00: m_wen = 1'b0;
                    2'b10: if (BULK && m_wen) begin
                        for (int i = 0; i < 64; i++) m_mem[i] = 16'hFFFF;
                        commit = 1'b1;
                    end
                    default: if (BULK && m_wen && ndata == 16) begin
                        for (int i = 0; i < 64; i++) m_mem[i] = data;
                        commit = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
        #60;
        check({tag, ":busy"}, busy, commit);
        check({tag, ":wen"}, wen, m_wen);
        if (commit) begin
            if (probe) begin
                #40;
                cs = 1'b1;
                #100;
                check({tag, ":busy_do"}, {dout_oe, dout}, 2'b10);
                #460;
            end else begin
                #600;
            end
            check({tag, ":busy_end-1"}, busy, 1'b1);
            #10;
            check({tag, ":busy_end"}, busy, 1'b0);
            if (probe) begin
                check({tag, ":ready"}, {dout_oe, dout}, 2'b11);
                cs = 1'b0;
            end
        end
        #100;
    endtask

    task automatic run_read(input string tag, input logic [5:0] addr, input int nwords);
        logic [15:0] w;
        logic        oe_ok;
        logic [5:0]  a;
        cs_on();
        send_bits({24'd0, 1'b1, 2'b10, addr[5:1]}, 8);
        di = addr[0];
        #HALF;
        sk = 1'b1;
        #40;
        check({tag, ":dummy"}, {dout_oe, dout}, 2'b10);
        #10;
        sk = 1'b0;
        a = addr;
        for (int k = 0; k < nwords; k++) begin
            oe_ok = 1'b1;
            for (int b = 15; b >= 0; b--) begin
                #HALF;
                w[b]  = dout;
                oe_ok = oe_ok & dout_oe;
                sk    = 1'b1;
                #HALF;
                sk    = 1'b0;
            end
            check({tag, ":data"}, w, m_mem[a]);
            check({tag, ":oe"}, oe_ok, 1'b1);
            a = a + 6'd1;
        end
        #HALF;
        cs = 1'b0;
        #40;
        check({tag, ":oe_off"}, dout_oe, 1'b0);
        #60;
    endtask

    initial begin
        int          kind;
        int          nd;
        logic [5:0]  ra;
        logic [15:0] rd;

        model_reset();
        #100;
        rst_n = 1'b1;
        #100;
        check("rst_state", {dout, dout_oe, busy, wen}, 4'b0000);

        run_read("rd05_init", 6'h05, 1);
        run_cmd("ewen", 2'b00, 6'h30, 16'h0, 0, 1'b0);
        run_cmd("wr05", 2'b01, 6'h05, 16'hA5C3, 16, 1'b1);
        run_read("rd05", 6'h05, 1);

        run_cmd("wr3f", 2'b01, 6'h3F, 16'h1234, 16, 1'b0);
        run_cmd("wr00", 2'b01, 6'h00, 16'h5678, 16, 1'b0);
        run_read("seq", 6'h3F, 2);

        run_cmd("ewds", 2'b00, 6'h00, 16'h0, 0, 1'b0);
        run_cmd("wr10_prot", 2'b01, 6'h10, 16'h0000, 16, 1'b0);
        run_read("rd10", 6'h10, 1);

        run_cmd("ewen2", 2'b00, 6'h3A, 16'h0, 0, 1'b0);
        run_cmd("wr07_short", 2'b01, 6'h07, 16'hBEEF, 9, 1'b0);
        run_read("rd07", 6'h07, 1);

        run_cmd("wral", 2'b00, 6'h10, 16'h0F0F, 16, 1'b0);
        run_read("rdall", 6'h00, 64);

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 11));
            ra   = 6'($urandom_range(0, 63));
            rd   = 16'($urandom);
            case (kind)
                0, 1, 2: begin
                    nd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
                    run_cmd("rnd_write", 2'b01, ra, rd, nd, 1'b0);
                end
                3:       run_cmd("rnd_erase", 2'b11, ra, 16'h0, 0, 1'b0);
                4, 5:    run_cmd("rnd_ewen", 2'b00, {2'b11, ra[3:0]}, 16'h0, 0, 1'b0);
                6:       run_cmd("rnd_ewds", 2'b00, {2'b00, ra[3:0]}, 16'h0, 0, 1'b0);
                7: begin
                    if ($urandom_range(0, 2) == 0)
                        run_cmd("rnd_eral", 2'b00, {2'b10, ra[3:0]}, 16'h0, 0, 1'b0);
                    else
                        run_cmd("rnd_wral", 2'b00, {2'b01, ra[3:0]}, rd, 16, 1'b0);
                end
                default: run_read("rnd_read", ra, int'($urandom_range(1, 2)));
            endcase
        end

        // Asynchronous reset in the middle of a read re-initialises everything
        run_cmd("ewen3", 2'b00, 6'h30, 16'h0, 0, 1'b0);
        run_cmd("wr05b", 2'b01, 6'h05, 16'h3C3C, 16, 1'b0);
        cs_on();
        send_bits({23'd0, 1'b1, 2'b10, 6'h05}, 9);
        #HALF;
        check("pre_rst_oe", dout_oe, 1'b1);
        rst_n = 1'b0;
        #10;
        check("mid_rst_state", {dout, dout_oe, busy, wen}, 4'b0000);
        cs = 1'b0;
        sk = 1'b0;
        #40;
        rst_n = 1'b1;
        model_reset();
        #100;
        run_read("rd05_after_rst", 6'h05, 1);
        check("wen_after_rst", wen, m_wen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
